instruction_cache_array: RTL

Direct-mapped instruction cache storage for the IF stage: tag array, valid bits, and data array.

- Performs the fetch lookup combinationally and raises `miss` to the instruction cache controller.
- Absorbs the refill words the controller forwards from AXI3, one per `refill_valid` beat.
- Returns the fetched instruction word to the controller.

---
 rtl/icache_pkg.sv | 16 +
 rtl/icache_data_ram.sv | 40 ++++
 rtl/instruction_cache_array.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: constants and the state encoding shared by the instruction
// cache storage array and the instruction cache controller.
package icache_pkg;

    localparam int unsigned DATA_LENGTH    = 32;
    localparam int unsigned LINE_SIZE      = 64;
    localparam int unsigned WORDS_PER_LINE = LINE_SIZE * 8 / DATA_LENGTH;
    localparam int unsigned OFFSET_BITS    = 6;
    localparam int unsigned WORD_SEL_BITS  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_data_ram.sv
// icache_data_ram: instruction data storage, NUM_LINES x WORDS x WIDTH.
// Ports:
//   clk        clock
//   we_i       write enable for the synchronous write port
//   wr_line_i  write line index
//   wr_word_i  write word index within the line
//   wr_data_i  write data
//   rd_line_i  read line index (combinational read)
//   rd_word_i  read word index within the line
//   rd_data_o  read data
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned WORDS     = 16,
    parameter int unsigned WIDTH     = 32,
    localparam int unsigned LINE_BITS = $clog2(NUM_LINES),
    localparam int unsigned WORD_BITS = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [LINE_BITS-1:0] wr_line_i,
    input  logic [WORD_BITS-1:0] wr_word_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    input  logic [LINE_BITS-1:0] rd_line_i,
    input  logic [WORD_BITS-1:0] rd_word_i,
    output logic [WIDTH-1:0]     rd_data_o
);

    logic [WIDTH-1:0] mem_q [NUM_LINES][WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_line_i][wr_word_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_line_i][rd_word_i];

endmodule

// File: rtl/instruction_cache_array.sv
// instruction_cache_array: direct-mapped instruction cache storage (tags,
// valid bits, data) with combinational fetch lookup and line refill.
// Ports:
//   clk              clock
//   rst              asynchronous active-high reset
//   addr             fetch byte address (addr[1:0] ignored)
//   flush            invalidate all lines, abort any refill
//   refill_valid     one refill word on refill_data this cycle
//   refill_data      refill word, ascending word order from offset 0
//   miss             lookup missed or a refill is in progress
//   refill_complete  one-cycle pulse after the last word of a line is written
//   data_out         instruction word on a hit, 0 otherwise
module instruction_cache_array #(
    parameter int unsigned DATA_LENGTH = icache_pkg::DATA_LENGTH,
    parameter int unsigned LINE_SIZE   = icache_pkg::LINE_SIZE,
    parameter int unsigned NUM_LINES   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic                   flush,
    input  logic                   refill_valid,
    input  logic [DATA_LENGTH-1:0] refill_data,
    output logic                   miss,
    output logic                   refill_complete,
    output logic [DATA_LENGTH-1:0] data_out
);

    import icache_pkg::*;

    localparam int unsigned WORDS_PER_LINE = LINE_SIZE * 8 / DATA_LENGTH;
    localparam int unsigned INDEX_BITS     = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS       = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int unsigned CNT_BITS       = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WORDS_PER_LINE - 1);

    icache_state_e          state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [INDEX_BITS-1:0]  refill_index_q, refill_index_d;
    logic [TAG_BITS-1:0]    refill_tag_q, refill_tag_d;
    logic                   refill_complete_q, refill_complete_d;
    logic [TAG_BITS-1:0]    tag_q [NUM_LINES];

    logic [INDEX_BITS-1:0]    idx;
    logic [TAG_BITS-1:0]      tag;
    logic [WORD_SEL_BITS-1:0] word_sel;
    logic [1:0]               unused_byte_sel;
    logic                     hit;
    logic                     tag_we;
    logic                     ram_we;
    logic [DATA_LENGTH-1:0]   rd_data;

    assign idx             = addr[OFFSET_BITS +: INDEX_BITS];
    assign tag             = addr[31 -: TAG_BITS];
    assign word_sel        = addr[OFFSET_BITS-1 -: WORD_SEL_BITS];
    assign unused_byte_sel = addr[1:0];

    assign hit = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag) && !flush;

    assign miss            = !hit;
    assign data_out        = hit ? rd_data : '0;
    assign refill_complete = refill_complete_q;
    assign ram_we          = (state_q == REFILL) && refill_valid && !flush;

    icache_data_ram #(
        .NUM_LINES (NUM_LINES),
        .WORDS     (WORDS_PER_LINE),
        .WIDTH     (DATA_LENGTH)
    ) u_data_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .wr_line_i (refill_index_q),
        .wr_word_i (cnt_q),
        .wr_data_i (refill_data),
        .rd_line_i (idx),
        .rd_word_i (word_sel),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        valid_d           = valid_q;
        refill_index_d    = refill_index_q;
        refill_tag_d      = refill_tag_q;
        refill_complete_d = 1'b0;
        tag_we            = 1'b0;

        if (flush) begin
            // Flush overrides everything: no refill start, no word write,
            // no line validation.
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!hit) begin
                        refill_index_d = idx;
                        refill_tag_d   = tag;
                        valid_d[idx]   = 1'b0;
                        cnt_d          = '0;
                        state_d        = REFILL;
                    end
                end
                REFILL: begin
                    if (refill_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            valid_d[refill_index_q] = 1'b1;
                            tag_we                  = 1'b1;
                            cnt_d                   = '0;
                            refill_complete_d       = 1'b1;
                            state_d                 = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            valid_q           <= '0;
            refill_index_q    <= '0;
            refill_tag_q      <= '0;
            refill_complete_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            valid_q           <= valid_d;
            refill_index_q    <= refill_index_d;
            refill_tag_q      <= refill_tag_d;
            refill_complete_q <= refill_complete_d;
        end
    end

    // Tag storage is deliberately not reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[refill_index_q] <= refill_tag_q;
        end
    end

endmodule
